// File: rtl/datapath_bus_pkg.sv
// -----------------------------------------------------------------------------
// datapath_pkg
// Shared encodings between the datapath and the control unit that drives it:
//   - bus source select codes carried on read_en
//   - bit positions inside the write_en / inc_en / clr_en strobe vectors
//   - ALU function codes carried on alu_op
// -----------------------------------------------------------------------------
package datapath_pkg;

    localparam int DP_DW = 16;
    localparam int DP_AW = 10;

    typedef logic [3:0] src_sel_t;
    typedef logic [2:0] alu_op_t;

    // Bus source codes; 3, 11, 14 and 15 are reserved and behave as hold.
    localparam src_sel_t SRC_HOLD = 4'd0;
    localparam src_sel_t SRC_PC   = 4'd1;
    localparam src_sel_t SRC_AR   = 4'd2;
    localparam src_sel_t SRC_IR   = 4'd4;
    localparam src_sel_t SRC_AC   = 4'd5;
    localparam src_sel_t SRC_R    = 4'd6;
    localparam src_sel_t SRC_R1   = 4'd7;
    localparam src_sel_t SRC_R2   = 4'd8;
    localparam src_sel_t SRC_R3   = 4'd9;
    localparam src_sel_t SRC_R4   = 4'd10;
    localparam src_sel_t SRC_DM   = 4'd12;
    localparam src_sel_t SRC_IM   = 4'd13;

    // Strobe bit indices, shared by write_en, inc_en and clr_en.
    localparam int W_PC  = 1;
    localparam int W_AR  = 2;
    localparam int W_IR  = 3;
    localparam int W_AC  = 4;
    localparam int W_R   = 5;
    localparam int W_R4  = 7;
    localparam int W_R3  = 8;
    localparam int W_R2  = 9;
    localparam int W_R1  = 10;
    localparam int W_DM  = 11;
    localparam int W_ALU = 12;

    // ALU function codes; every other code passes AC through unchanged.
    localparam alu_op_t OP_ADD = 3'd1;
    localparam alu_op_t OP_SUB = 3'd2;
    localparam alu_op_t OP_MUL = 3'd3;
    localparam alu_op_t OP_LSH = 3'd4;

endpackage

// File: rtl/datapath_bus_alu.sv
// -----------------------------------------------------------------------------
// dp_alu
// Purely combinational ALU operating on AC (a) and R (b).
// Ports:
//   a   in  DW  first operand (AC)
//   b   in  DW  second operand (R); only b[3:0] is used as the shift count
//   op  in  3   function select (datapath_pkg OP_* codes)
//   y   out DW  result, truncated to DW bits
// -----------------------------------------------------------------------------
module dp_alu
    import datapath_pkg::*;
#(
    parameter int DW = DP_DW
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [2:0]    op,
    output logic [DW-1:0] y
);

    // Function select; all results keep only the low DW bits.
    always_comb begin
        y = a;
        case (op)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_MUL:  y = a * b;
            OP_LSH:  y = a << b[3:0];
            default: y = a;
        endcase
    end

endmodule

// File: rtl/datapath_bus.sv
// -----------------------------------------------------------------------------
// datapath_bus
// Register file + registered shared bus + ALU executing the control unit's
// per-cycle strobes. Owns PC, AR, IR, AC, R, R1..R4 and bus_q.
// Ports:
//   clk          in  1   clock, rising edge
//   rst          in  1   synchronous active-high reset (overrides all strobes)
//   read_en      in  4   bus source select (SRC_* codes)
//   write_en     in  16  per-destination write strobes (W_* bits)
//   inc_en       in  16  increment strobes (PC, AC)
//   clr_en       in  16  clear strobes (PC, AR, IR, AC, R)
//   alu_op       in  3   ALU function
//   instruction  out 6   IR opcode field
//   z            out DW  1 when AC is zero
//   im_addr      out AW  instruction memory address (PC)
//   im_rdata     in  DW  instruction memory data
//   dm_addr      out AW  data memory address (AR)
//   dm_rdata     in  DW  data memory read data
//   dm_wdata     out DW  data memory write data (bus_q)
//   dm_we        out 1   data memory write enable
// -----------------------------------------------------------------------------
module datapath_bus
    import datapath_pkg::*;
#(
    parameter int DW = DP_DW,
    parameter int AW = DP_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    read_en,
    input  logic [15:0]   write_en,
    input  logic [15:0]   inc_en,
    input  logic [15:0]   clr_en,
    input  logic [2:0]    alu_op,
    output logic [5:0]    instruction,
    output logic [DW-1:0] z,
    output logic [AW-1:0] im_addr,
    input  logic [DW-1:0] im_rdata,
    output logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_rdata,
    output logic [DW-1:0] dm_wdata,
    output logic          dm_we
);

    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] ar_q, ar_d;
    logic [DW-1:0] ir_q, ir_d;
    logic [DW-1:0] ac_q, ac_d;
    logic [DW-1:0] r_q,  r_d;
    logic [DW-1:0] r1_q, r1_d;
    logic [DW-1:0] r2_q, r2_d;
    logic [DW-1:0] r3_q, r3_d;
    logic [DW-1:0] r4_q, r4_d;
    logic [DW-1:0] bus_q, bus_d;
    logic [DW-1:0] alu_y_s;
    logic          unused_strobes_s;

    // Strobe bits with no destination in this datapath.
    assign unused_strobes_s = ^{write_en[15:13], write_en[6], write_en[0],
                                inc_en[15:5], inc_en[3:2], inc_en[0],
                                clr_en[15:6], clr_en[0]};

    dp_alu #(.DW(DW)) u_alu (
        .a  (ac_q),
        .b  (r_q),
        .op (alu_op),
        .y  (alu_y_s)
    );

    // Bus source mux; reserved codes fall into default and hold.
    always_comb begin
        bus_d = bus_q;
        case (read_en)
            SRC_HOLD: bus_d = bus_q;
            SRC_PC:   bus_d = {{(DW-AW){1'b0}}, pc_q};
            SRC_AR:   bus_d = {{(DW-AW){1'b0}}, ar_q};
            SRC_IR:   bus_d = ir_q;
            SRC_AC:   bus_d = ac_q;
            SRC_R:    bus_d = r_q;
            SRC_R1:   bus_d = r1_q;
            SRC_R2:   bus_d = r2_q;
            SRC_R3:   bus_d = r3_q;
            SRC_R4:   bus_d = r4_q;
            SRC_DM:   bus_d = dm_rdata;
            SRC_IM:   bus_d = im_rdata;
            default:  bus_d = bus_q;
        endcase
    end

    // PC next state: clear > write > increment (wraps at 2^AW).
    always_comb begin
        if (clr_en[W_PC]) begin
            pc_d = {AW{1'b0}};
        end else if (write_en[W_PC]) begin
            pc_d = bus_q[AW-1:0];
        end else if (inc_en[W_PC]) begin
            pc_d = pc_q + {{(AW-1){1'b0}}, 1'b1};
        end else begin
            pc_d = pc_q;
        end
    end

    // AC next state: clear > ALU write-back > bus write > increment.
    always_comb begin
        if (clr_en[W_AC]) begin
            ac_d = {DW{1'b0}};
        end else if (write_en[W_ALU]) begin
            ac_d = alu_y_s;
        end else if (write_en[W_AC]) begin
            ac_d = bus_q;
        end else if (inc_en[W_AC]) begin
            ac_d = ac_q + {{(DW-1){1'b0}}, 1'b1};
        end else begin
            ac_d = ac_q;
        end
    end

    // AR, IR and R: clear > write. R1..R4 are write-only.
    always_comb begin
        if (clr_en[W_AR]) begin
            ar_d = {AW{1'b0}};
        end else if (write_en[W_AR]) begin
            ar_d = bus_q[AW-1:0];
        end else begin
            ar_d = ar_q;
        end

        if (clr_en[W_IR]) begin
            ir_d = {DW{1'b0}};
        end else if (write_en[W_IR]) begin
            ir_d = bus_q;
        end else begin
            ir_d = ir_q;
        end

        if (clr_en[W_R]) begin
            r_d = {DW{1'b0}};
        end else if (write_en[W_R]) begin
            r_d = bus_q;
        end else begin
            r_d = r_q;
        end

        r1_d = write_en[W_R1] ? bus_q : r1_q;
        r2_d = write_en[W_R2] ? bus_q : r2_q;
        r3_d = write_en[W_R3] ? bus_q : r3_q;
        r4_d = write_en[W_R4] ? bus_q : r4_q;
    end

    // State registers; reset wins over every strobe, including the bus load.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q  <= {AW{1'b0}};
            ar_q  <= {AW{1'b0}};
            ir_q  <= {DW{1'b0}};
            ac_q  <= {DW{1'b0}};
            r_q   <= {DW{1'b0}};
            r1_q  <= {DW{1'b0}};
            r2_q  <= {DW{1'b0}};
            r3_q  <= {DW{1'b0}};
            r4_q  <= {DW{1'b0}};
            bus_q <= {DW{1'b0}};
        end else begin
            pc_q  <= pc_d;
            ar_q  <= ar_d;
            ir_q  <= ir_d;
            ac_q  <= ac_d;
            r_q   <= r_d;
            r1_q  <= r1_d;
            r2_q  <= r2_d;
            r3_q  <= r3_d;
            r4_q  <= r4_d;
            bus_q <= bus_d;
        end
    end

    assign instruction = ir_q[DW-1:DW-6];
    assign z           = {{(DW-1){1'b0}}, (ac_q == {DW{1'b0}})};
    assign im_addr     = pc_q;
    assign dm_addr     = ar_q;
    assign dm_wdata    = bus_q;
    // Write strobe passes straight through so DM commits on the same edge.
    assign dm_we       = write_en[W_DM];

endmodule
